// File: rtl/rv32i_fetch_decode_stage.sv
// RV32I fetch stage with single-outstanding imem port and IF/ID pipeline register.
// Optional macro RV32I_FETCH_MISALIGN_CHK_EN enables the sticky misaligned-redirect flag.
module rv32i_fetch_decode_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallF,
  input  logic            flushF,
  input  logic            stallD,
  input  logic            flushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] PCF,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            validD,
  output logic            misalign_err
);

  typedef enum logic [1:0] {StIdle, StWait, StHold, StDrop} state_e;

  localparam logic [XLEN-1:0] PcStep = XLEN'(4);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [31:0]     buf_q, buf_d;
  logic [31:0]     instrd_q, instrd_d;
  logic [XLEN-1:0] pcd_q, pcd_d;
  logic [XLEN-1:0] pcplus4d_q, pcplus4d_d;
  logic            validd_q, validd_d;

  logic            kill;
  logic            deliver;
  logic [31:0]     deliver_instr;
  logic [XLEN-1:0] redirect_pc;

  assign kill        = PCSrcE | flushF;
  assign redirect_pc = {PCTargetE[XLEN-1:2], 2'b00};

  // Fetch FSM: one request in flight; a kill while outstanding parks in StDrop.
  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    deliver       = 1'b0;
    deliver_instr = buf_q;
    imem_req      = 1'b0;
    unique case (state_q)
      StIdle: begin
        imem_req = ~stallF & ~rst;
        // A request accepted alongside a kill fetches a stale PC.
        if (imem_req && imem_gnt) begin
          state_d = kill ? StDrop : StWait;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          if (kill) begin
            state_d = StIdle;
          end else if (stallD) begin
            buf_d   = imem_rdata;
            state_d = StHold;
          end else begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
            state_d       = StIdle;
          end
        end else if (kill) begin
          state_d = StDrop;
        end
      end
      StHold: begin
        if (kill) begin
          state_d = StIdle;
        end else if (!stallD) begin
          deliver = 1'b1;
          state_d = StIdle;
        end
      end
      StDrop: begin
        if (imem_rvalid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pcf_d = pcf_q;
    if (PCSrcE) begin
      pcf_d = redirect_pc;
    end else if (stallF) begin
      pcf_d = pcf_q;
    end else if (deliver) begin
      pcf_d = pcf_q + PcStep;
    end
  end

  // The delivered instruction always belongs to PCF: PCF cannot move while a fetch is live.
  always_comb begin
    instrd_d   = instrd_q;
    pcd_d      = pcd_q;
    pcplus4d_d = pcplus4d_q;
    validd_d   = validd_q;
    if (flushD || PCSrcE) begin
      instrd_d = NOP_INSTR;
      validd_d = 1'b0;
    end else if (stallD) begin
      validd_d = validd_q;
    end else if (deliver) begin
      instrd_d   = deliver_instr;
      pcd_d      = pcf_q;
      pcplus4d_d = pcf_q + PcStep;
      validd_d   = 1'b1;
    end else begin
      instrd_d = NOP_INSTR;
      validd_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pcf_q      <= RESET_PC;
      buf_q      <= NOP_INSTR;
      instrd_q   <= NOP_INSTR;
      pcd_q      <= '0;
      pcplus4d_q <= '0;
      validd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcf_q      <= pcf_d;
      buf_q      <= buf_d;
      instrd_q   <= instrd_d;
      pcd_q      <= pcd_d;
      pcplus4d_q <= pcplus4d_d;
      validd_q   <= validd_d;
    end
  end

`ifdef RV32I_FETCH_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q;
    if (PCSrcE && (PCTargetE[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_err = misalign_q;
`else
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^PCTargetE[1:0];
  assign misalign_err   = 1'b0;
`endif

  assign imem_addr = pcf_q;
  assign PCF       = pcf_q;
  assign InstrD    = instrd_q;
  assign PCD       = pcd_q;
  assign PCPlus4D  = pcplus4d_q;
  assign validD    = validd_q;

endmodule

// File: tb/tb_rv32i_fetch_decode_stage.sv
// Directed bench for rv32i_fetch_decode_stage: fetch cadence, stalls, redirects, flushes,
// PC wrap, reset abort and the misaligned-redirect flag.
module tb_rv32i_fetch_decode_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stallF, flushF, stallD, flushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        validD, misalign_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  rv32i_fetch_decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stallF      (stallF),
    .flushF      (flushF),
    .stallD      (stallD),
    .flushD      (flushD),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .PCF         (PCF),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .validD      (validD),
    .misalign_err(misalign_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stallF = 0; flushF = 0; stallD = 0; flushD = 0; PCSrcE = 0;
    PCTargetE = '0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    step(); step();
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL reset_pcf got %h exp %h", PCF, 32'h0); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (InstrD !== Nop) begin errors++; $display("FAIL reset_instrd got %h exp %h", InstrD, Nop); end
    checks++; if (validD !== 1'b0) begin errors++; $display("FAIL reset_validd got %b exp 0", validD); end
    checks++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) begin
      errors++; $display("FAIL reset_pcd got %h/%h exp 0/0", PCD, PCPlus4D);
    end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", misalign_err); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL idle_req got %b exp 1", imem_req); end
    exp_pc = 32'h0;
  endtask

  task automatic test_fetch();
    logic [31:0] instrs [3];
    instrs[0] = 32'h0050_0093; instrs[1] = 32'h0010_8113; instrs[2] = 32'h0020_0193;
    for (int i = 0; i < 3; i++) begin
      imem_gnt = 1'b1; imem_rvalid = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
        errors++; $display("FAIL fetch_req%0d got %b/%h exp 1/%h", i, imem_req, imem_addr, exp_pc);
      end
      step();
      if (i > 0) begin
        checks++; if (validD !== 1'b0) begin errors++; $display("FAIL fetch_bubble%0d got %b exp 0", i, validD); end
      end
      imem_rvalid = 1'b1; imem_rdata = instrs[i];
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wait_req%0d got %b exp 0", i, imem_req); end
      step();
      imem_rvalid = 1'b0;
      checks++; if (InstrD !== instrs[i] || validD !== 1'b1) begin
        errors++; $display("FAIL fetch_instr%0d got %h/%b exp %h/1", i, InstrD, validD, instrs[i]);
      end
      checks++; if (PCD !== exp_pc || PCPlus4D !== exp_pc + 4) begin
        errors++; $display("FAIL fetch_pcd%0d got %h/%h exp %h/%h", i, PCD, PCPlus4D, exp_pc, exp_pc + 4);
      end
      exp_pc = exp_pc + 4;
      checks++; if (PCF !== exp_pc) begin errors++; $display("FAIL fetch_pcf%0d got %h exp %h", i, PCF, exp_pc); end
    end
  endtask

  task automatic test_stall_d();
    imem_gnt = 1'b1;
    step();
    stallD = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h00C0_0213;
    step();
    imem_rvalid = 1'b0;
    checks++; if (InstrD !== Nop || validD !== 1'b0 || PCF !== exp_pc) begin
      errors++; $display("FAIL hold_entry got %h/%b/%h exp %h/0/%h", InstrD, validD, PCF, Nop, exp_pc);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (imem_req !== 1'b0 || PCF !== exp_pc || validD !== 1'b0) begin
        errors++; $display("FAIL hold_cycle%0d got %b/%h/%b exp 0/%h/0", i, imem_req, PCF, validD, exp_pc);
      end
    end
    stallD = 1'b0;
    step();
    checks++; if (InstrD !== 32'h00C0_0213 || validD !== 1'b1 || PCD !== exp_pc) begin
      errors++; $display("FAIL hold_release got %h/%b/%h exp 00c00213/1/%h", InstrD, validD, PCD, exp_pc);
    end
    exp_pc = exp_pc + 4;
    checks++; if (PCF !== exp_pc) begin errors++; $display("FAIL hold_pcf got %h exp %h", PCF, exp_pc); end
  endtask

  task automatic test_redirect();
    imem_gnt = 1'b1;
    step();
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    step();
    PCSrcE = 1'b0;
    #1;
    checks++; if (PCF !== 32'h100 || imem_req !== 1'b0) begin
      errors++; $display("FAIL redirect_drop got %h/%b exp 00000100/0", PCF, imem_req);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    checks++; if (validD !== 1'b0 || InstrD !== Nop || PCF !== 32'h100) begin
      errors++; $display("FAIL redirect_discard got %b/%h/%h exp 0/%h/00000100", validD, InstrD, PCF, Nop);
    end
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL redirect_addr got %b/%h exp 1/00000100", imem_req, imem_addr);
    end
  endtask

  task automatic test_flush_d();
    imem_gnt = 1'b1;
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; flushD = 1'b1;
    step();
    imem_rvalid = 1'b0; flushD = 1'b0;
    checks++; if (InstrD !== Nop || validD !== 1'b0) begin
      errors++; $display("FAIL flushd_instr got %h/%b exp %h/0", InstrD, validD, Nop);
    end
    checks++; if (PCF !== 32'h104) begin errors++; $display("FAIL flushd_pcf got %h exp 00000104", PCF); end
  endtask

  task automatic test_wrap();
    imem_gnt = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    step();
    PCSrcE = 1'b0; imem_gnt = 1'b1;
    checks++; if (PCF !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup got %h exp fffffffc", PCF); end
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033;
    step();
    imem_rvalid = 1'b0;
    checks++; if (PCF !== 32'h0 || PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0 || validD !== 1'b1) begin
      errors++; $display("FAIL wrap_pc got %h/%h/%h/%b exp 0/fffffffc/0/1", PCF, PCD, PCPlus4D, validD);
    end
  endtask

  task automatic test_reset_mid();
    imem_gnt = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h200;
    step();
    PCSrcE = 1'b0; imem_gnt = 1'b1;
    step();
    rst = 1'b1; imem_gnt = 1'b0;
    step();
    rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_rvalid = 1'b0;
    checks++; if (validD !== 1'b0 || PCF !== 32'h0 || InstrD !== Nop) begin
      errors++; $display("FAIL rstmid_nodeliver got %b/%h/%h exp 0/0/%h", validD, PCF, InstrD, Nop);
    end
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL rstmid_idle got %b/%h exp 1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_stall_f();
    stallF = 1'b1; imem_gnt = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stallf_req got %b exp 0", imem_req); end
    step();
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL stallf_pcf got %h exp 0", PCF); end
    stallF = 1'b0; imem_gnt = 1'b0;
  endtask

  task automatic test_misalign();
    logic exp_mis;
`ifdef RV32I_FETCH_MISALIGN_CHK_EN
    exp_mis = 1'b1;
`else
    exp_mis = 1'b0;
`endif
    imem_gnt = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h102;
    step();
    PCSrcE = 1'b0;
    checks++; if (PCF !== 32'h100) begin errors++; $display("FAIL misalign_pcf got %h exp 00000100", PCF); end
    checks++; if (misalign_err !== exp_mis) begin
      errors++; $display("FAIL misalign_set got %b exp %b", misalign_err, exp_mis);
    end
    step();
    checks++; if (misalign_err !== exp_mis) begin
      errors++; $display("FAIL misalign_sticky got %b exp %b", misalign_err, exp_mis);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL misalign_clear got %b exp 0", misalign_err); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall_d();
    test_redirect();
    test_flush_d();
    test_wrap();
    test_reset_mid();
    test_stall_f();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
